rgb_frame_switch: RTL and testbench
===================================

// Module: rgb_frame_switch
// PURPOSE
//   Parametrised N-channel RGB video source switcher with tear-free switching.
//   Selection changes commit only on a frame boundary (active vsync edge).
//   An optional run of black frames follows each switch.
//   Sits between several same-timing video sources and the display timing/output stage.
// PARAMETERS
//   NUM_CH        8    number of input channels (2..16)
//   DATA_W        24   pixel width per channel
//   SEL_W         3    select width; NUM_CH <= 2**SEL_W
//   BLANK_FRAMES  0    black frames inserted after each switch (0 = none, max 15)
//   VS_POL        1    vsync active level; 1 = active-high, boundary = rising edge
// PORTS
//   clk            in   1              pixel clock
//   rst            in   1              asynchronous, active-high reset
//   i_rgb          in   NUM_CH*DATA_W  channel k on bits [k*DATA_W +: DATA_W]
//   i_hsync        in   1              shared hsync, all channels
//   i_vsync        in   1              shared vsync, all channels
//   i_de           in   1              shared data enable, all channels
//   switch         in   SEL_W          requested channel (level, sampled every cycle)
//   o_rgb          out  DATA_W         selected pixel, registered
//   o_hsync        out  1              i_hsync delayed 1 cycle
//   o_vsync        out  1              i_vsync delayed 1 cycle
//   o_de           out  1              i_de delayed 1 cycle
//   o_active_ch    out  SEL_W          channel currently driving o_rgb
//   o_pending      out  1              request differs from o_active_ch, awaiting boundary
// BEHAVIOUR
//   - Reset (async assert, sync deassert by clk): o_rgb=0, o_hsync=o_vsync=o_de=0,
//     o_active_ch=0, o_pending=0, FSM=RUN, blank counter=0.
//   - Latency is 1 clk for all outputs, so syncs/de stay aligned with o_rgb.
//   - Output data rule:
//       o_rgb = 0 when i_de=0 or FSM=BLANK;
//       otherwise o_rgb = channel active_ch.
//   - Boundary: vs_edge = vsync at VS_POL this cycle and at !VS_POL the previous cycle.
//     The previous-vsync register resets to !VS_POL.
//   - A request is valid when switch < NUM_CH and switch != active_ch.
//     An out-of-range request is ignored: no pending, active_ch held.
//   - FSM states:
//       RUN:     valid request -> PEND. o_pending=1 from the next cycle.
//       PEND:    request returns to active_ch or goes out of range -> RUN.
//                vs_edge with valid request -> active_ch <= switch (value sampled that
//                cycle), then BLANK if BLANK_FRAMES>0 (cnt <= BLANK_FRAMES), else RUN.
//       BLANK:   each vs_edge decrements cnt; leaves to RUN on the vs_edge where cnt
//                reaches 0. A request arriving in BLANK is held as pending.
//                It is acted on in RUN/PEND on a later boundary, never the same edge.
//   - New channel pixels reach o_rgb on the vs_edge cycle + 1, i.e. the first line of the
//     new frame. A frame is never mixed between channels.
//   - Request changes several times inside one frame: only the value present at vs_edge
//     commits.
//   - Request and vs_edge in the same cycle while in RUN: commits at the next boundary,
//     not this one (one frame minimum of PEND).
//   - o_pending = (FSM==PEND) or (FSM==BLANK and a valid request exists).
//   - Reset mid-frame or mid-blank: immediately returns to channel 0 with outputs zero.
//     Switching resumes from the first vs_edge after reset release.
//   - vsync held constant forever: PEND persists and active_ch never changes. No timeout.
// TESTING
//   1. Reset, switch=0, ch0=24'h112233, de=1 -> o_rgb=24'h112233 one clk after de;
//      with de=0, o_rgb=0.
//   2. switch 0->5 mid-frame -> o_pending=1; o_rgb stays ch0 until vs_edge;
//      ch5 appears vs_edge+1 and o_active_ch=5.
//   3. switch 0->3->6->0 within one frame -> o_pending drops to 0; no change at vs_edge.
//      Then 0->6 held through vs_edge -> active 6.
//   4. NUM_CH=6, switch=7 -> o_pending stays 0, active_ch unchanged, over 3 frames.
//   5. BLANK_FRAMES=2, switch 0->2 -> o_rgb=0 for 2 whole frames after commit edge;
//      ch2 from the 3rd frame. o_hsync/o_vsync/o_de keep toggling, 1-clk delayed.
//   6. Assert rst during BLANK of test 5 -> outputs 0, o_active_ch=0 asynchronously.
//      After release, ch0 passes at once.

Source files
------------

// File: rtl/rgb_frame_switch.sv
// ---------------------------------------------------------------------------
// rgb_frame_switch
//   N-channel RGB video source switcher with tear-free switching. A change of
//   the requested channel is only committed on a frame boundary (the active
//   vsync edge), so a frame is never built from two sources. An optional run of
//   black frames can follow each committed switch. All channels share one set
//   of hsync/vsync/de timing signals.
//
// Parameters
//   NUM_CH        number of input channels (2..16)
//   DATA_W        pixel width per channel
//   SEL_W         select width, NUM_CH <= 2**SEL_W
//   BLANK_FRAMES  black frames inserted after each switch (0 = none, max 15)
//   VS_POL        vsync active level (1 = active-high, boundary = rising edge)
//
// Ports
//   clk           pixel clock
//   rst           asynchronous active-high reset
//   i_rgb         channel k on bits [k*DATA_W +: DATA_W]
//   i_hsync       shared hsync
//   i_vsync       shared vsync
//   i_de          shared data enable
//   switch        requested channel, level sampled every cycle
//   o_rgb         selected pixel, registered (black outside de or while blanking)
//   o_hsync       i_hsync delayed one cycle
//   o_vsync       i_vsync delayed one cycle
//   o_de          i_de delayed one cycle
//   o_active_ch   channel currently driving o_rgb
//   o_pending     a valid request is waiting for a frame boundary
// ---------------------------------------------------------------------------
module rgb_frame_switch #(
    parameter int NUM_CH       = 8,
    parameter int DATA_W       = 24,
    parameter int SEL_W        = 3,
    parameter int BLANK_FRAMES = 0,
    parameter int VS_POL       = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH*DATA_W-1:0]   i_rgb,
    input  logic                       i_hsync,
    input  logic                       i_vsync,
    input  logic                       i_de,
    input  logic [SEL_W-1:0]           switch,
    output logic [DATA_W-1:0]          o_rgb,
    output logic                       o_hsync,
    output logic                       o_vsync,
    output logic                       o_de,
    output logic [SEL_W-1:0]           o_active_ch,
    output logic                       o_pending
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PEND  = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    localparam int             NUM_SLOTS  = 2 ** SEL_W;
    localparam logic           VS_ACT     = (VS_POL != 0);
    localparam logic [SEL_W:0] NUM_CH_L   = (SEL_W + 1)'(NUM_CH);
    localparam logic [3:0]     BLANK_INIT = 4'(BLANK_FRAMES);

    // State registers
    state_t             r_state;
    logic [SEL_W-1:0]   r_active;
    logic [3:0]         r_cnt;
    logic               r_vs_prev;
    logic [DATA_W-1:0]  r_rgb;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_de;

    // Combinational next-state values
    state_t             w_state_next;
    logic [SEL_W-1:0]   w_active_next;
    logic [3:0]         w_cnt_next;
    logic [DATA_W-1:0]  w_rgb_next;
    logic               w_vs_edge;
    logic               w_req_valid;

    // Channel table padded to a power of two so any select value indexes a
    // real entry; unused slots read as black.
    logic [DATA_W-1:0]  w_ch [NUM_SLOTS];

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_ch
            if (gi < NUM_CH) begin : g_used
                assign w_ch[gi] = i_rgb[gi*DATA_W +: DATA_W];
            end else begin : g_unused
                assign w_ch[gi] = '0;
            end
        end
    endgenerate

    // Frame boundary: vsync at its active level now, inactive last cycle.
    assign w_vs_edge   = (i_vsync == VS_ACT) && (r_vs_prev != VS_ACT);

    // Out-of-range requests are treated exactly like "no request".
    assign w_req_valid = ({1'b0, switch} < NUM_CH_L) && (switch != r_active);

    always_comb begin
        w_state_next  = r_state;
        w_active_next = r_active;
        w_cnt_next    = r_cnt;
        case (r_state)
            ST_RUN: begin
                // A request seen on a boundary cycle waits for the next one,
                // so every switch spends at least one frame in PEND.
                if (w_req_valid) begin
                    w_state_next = ST_PEND;
                end
            end
            ST_PEND: begin
                if (!w_req_valid) begin
                    w_state_next = ST_RUN;
                end else if (w_vs_edge) begin
                    w_active_next = switch;
                    if (BLANK_FRAMES > 0) begin
                        w_state_next = ST_BLANK;
                        w_cnt_next   = BLANK_INIT;
                    end else begin
                        w_state_next = ST_RUN;
                    end
                end
            end
            ST_BLANK: begin
                if (w_vs_edge) begin
                    w_cnt_next = r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        w_cnt_next = '0;
                        // A request held during blanking is committed on a
                        // later boundary, never on the one that ends blanking.
                        w_state_next = w_req_valid ? ST_PEND : ST_RUN;
                    end
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    // The pixel sampled on the boundary cycle is the first pixel of the new
    // frame, so it is selected with the post-boundary channel and blank state.
    always_comb begin
        w_rgb_next = '0;
        if (i_de && (w_state_next != ST_BLANK)) begin
            w_rgb_next = w_ch[w_active_next];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_RUN;
            r_active  <= '0;
            r_cnt     <= '0;
            r_vs_prev <= ~VS_ACT;
            r_rgb     <= '0;
            r_hsync   <= 1'b0;
            r_vsync   <= 1'b0;
            r_de      <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_active  <= w_active_next;
            r_cnt     <= w_cnt_next;
            r_vs_prev <= i_vsync;
            r_rgb     <= w_rgb_next;
            r_hsync   <= i_hsync;
            r_vsync   <= i_vsync;
            r_de      <= i_de;
        end
    end

    assign o_rgb       = r_rgb;
    assign o_hsync     = r_hsync;
    assign o_vsync     = r_vsync;
    assign o_de        = r_de;
    assign o_active_ch = r_active;
    assign o_pending   = (r_state == ST_PEND) ||
                         ((r_state == ST_BLANK) && w_req_valid);

endmodule

// File: tb/tb_rgb_frame_switch.sv
// ---------------------------------------------------------------------------
// tb_rgb_frame_switch
//   Two instances share all inputs: dut A (8 channels, no blanking) and
//   dut B (6 channels, 2 blank frames). Each driven cycle pushes its expected
//   outputs onto a queue; the entry is popped and compared one clock later.
// ---------------------------------------------------------------------------
module tb_rgb_frame_switch;

    localparam int DW = 24;
    localparam logic [DW-1:0] C0 = 24'h112233;
    localparam logic [DW-1:0] C2 = 24'h222222;
    localparam logic [DW-1:0] C5 = 24'h555555;
    localparam logic [DW-1:0] C6 = 24'h666666;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [8*DW-1:0]   ch_bus;
    logic              i_hsync = 1'b0;
    logic              i_vsync = 1'b0;
    logic              i_de    = 1'b0;
    logic [2:0]        sw      = 3'd0;

    logic [DW-1:0]     a_rgb, b_rgb;
    logic              a_hs, a_vs, a_de, b_hs, b_vs, b_de;
    logic [2:0]        a_act, b_act;
    logic              a_pend, b_pend;

    always #5 clk = ~clk;

    rgb_frame_switch #(
        .NUM_CH(8), .DATA_W(DW), .SEL_W(3), .BLANK_FRAMES(0), .VS_POL(1)
    ) dut_a (
        .clk(clk), .rst(rst), .i_rgb(ch_bus),
        .i_hsync(i_hsync), .i_vsync(i_vsync), .i_de(i_de), .switch(sw),
        .o_rgb(a_rgb), .o_hsync(a_hs), .o_vsync(a_vs), .o_de(a_de),
        .o_active_ch(a_act), .o_pending(a_pend)
    );

    rgb_frame_switch #(
        .NUM_CH(6), .DATA_W(DW), .SEL_W(3), .BLANK_FRAMES(2), .VS_POL(1)
    ) dut_b (
        .clk(clk), .rst(rst), .i_rgb(ch_bus[6*DW-1:0]),
        .i_hsync(i_hsync), .i_vsync(i_vsync), .i_de(i_de), .switch(sw),
        .o_rgb(b_rgb), .o_hsync(b_hs), .o_vsync(b_vs), .o_de(b_de),
        .o_active_ch(b_act), .o_pending(b_pend)
    );

    typedef struct {
        bit              dsel;   // 0 = dut A, 1 = dut B
        logic [DW-1:0]   rgb;
        logic            hs;
        logic            vs;
        logic            de;
        logic [2:0]      act;
        logic            pend;
    } exp_t;

    typedef struct {
        logic            vs;
        logic            de;
        logic [2:0]      sw;
        logic [DW-1:0]   rgb;
        logic [2:0]      act;
        logic            pend;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[25];
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_txn   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Pop one scoreboard entry and compare it with the selected instance.
    task automatic check_out();
        exp_t          e;
        logic [DW-1:0] g_rgb;
        logic          g_hs, g_vs, g_de, g_pend;
        logic [2:0]    g_act;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        if (e.dsel) begin
            g_rgb = b_rgb; g_hs = b_hs; g_vs = b_vs; g_de = b_de; g_act = b_act; g_pend = b_pend;
        end else begin
            g_rgb = a_rgb; g_hs = a_hs; g_vs = a_vs; g_de = a_de; g_act = a_act; g_pend = a_pend;
        end
        $display("txn %0d dut%s rgb=%h hs=%0b vs=%0b de=%0b act=%0d pend=%0b",
                 n_txn, e.dsel ? "B" : "A", g_rgb, g_hs, g_vs, g_de, g_act, g_pend);
        chk("o_rgb",       32'(g_rgb),  32'(e.rgb));
        chk("o_hsync",     32'(g_hs),   32'(e.hs));
        chk("o_vsync",     32'(g_vs),   32'(e.vs));
        chk("o_de",        32'(g_de),   32'(e.de));
        chk("o_active_ch", 32'(g_act),  32'(e.act));
        chk("o_pending",   32'(g_pend), 32'(e.pend));
    endtask

    // Drive one cycle of inputs, record its expected outputs, check after the edge.
    task automatic step(input bit dsel, input logic vs, input logic de, input logic hs,
                        input logic [2:0] s, input logic [DW-1:0] ergb,
                        input logic [2:0] eact, input logic epend);
        exp_t e;
        @(negedge clk);
        i_vsync = vs; i_de = de; i_hsync = hs; sw = s;
        e.dsel = dsel; e.rgb = ergb; e.hs = hs; e.vs = vs; e.de = de;
        e.act = eact; e.pend = epend;
        sb.push_back(e);
        n_txn++;
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_a_rgb"},  32'(a_rgb),  32'd0);
        chk({tag, "_a_de"},   32'(a_de),   32'd0);
        chk({tag, "_a_act"},  32'(a_act),  32'd0);
        chk({tag, "_a_pend"}, 32'(a_pend), 32'd0);
        chk({tag, "_b_rgb"},  32'(b_rgb),  32'd0);
        chk({tag, "_b_hs"},   32'(b_hs),   32'd0);
        chk({tag, "_b_vs"},   32'(b_vs),   32'd0);
        chk({tag, "_b_de"},   32'(b_de),   32'd0);
        chk({tag, "_b_act"},  32'(b_act),  32'd0);
        chk({tag, "_b_pend"}, 32'(b_pend), 32'd0);
    endtask

    initial begin
        ch_bus = '0;
        ch_bus[DW-1:0] = C0;
        for (int k = 1; k < 8; k++) begin
            ch_bus[k*DW +: DW] = DW'(32'h111111 * k);
        end

        // {vs, de, sw, expected rgb, expected active, expected pending} on dut A
        vecs[0]  = '{1'b0, 1'b1, 3'd0, C0,    3'd0, 1'b0}; // ch0 passes
        vecs[1]  = '{1'b0, 1'b0, 3'd0, 24'h0, 3'd0, 1'b0}; // de=0 -> black
        vecs[2]  = '{1'b1, 1'b0, 3'd0, 24'h0, 3'd0, 1'b0}; // boundary, no request
        vecs[3]  = '{1'b0, 1'b1, 3'd0, C0,    3'd0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 3'd5, C0,    3'd0, 1'b1}; // request 5 mid-frame
        vecs[5]  = '{1'b0, 1'b1, 3'd5, C0,    3'd0, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 3'd5, 24'h0, 3'd5, 1'b0}; // commit on boundary
        vecs[7]  = '{1'b0, 1'b1, 3'd5, C5,    3'd5, 1'b0}; // ch5 in new frame
        vecs[8]  = '{1'b0, 1'b1, 3'd0, C5,    3'd5, 1'b1}; // back to 0
        vecs[9]  = '{1'b1, 1'b0, 3'd0, 24'h0, 3'd0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 3'd0, C0,    3'd0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 3'd3, C0,    3'd0, 1'b1}; // 0->3->6->0 in one frame
        vecs[12] = '{1'b0, 1'b1, 3'd6, C0,    3'd0, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 3'd0, C0,    3'd0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 3'd0, 24'h0, 3'd0, 1'b0}; // nothing commits
        vecs[15] = '{1'b0, 1'b1, 3'd0, C0,    3'd0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 3'd6, C0,    3'd0, 1'b1}; // 0->6 held
        vecs[17] = '{1'b1, 1'b0, 3'd6, 24'h0, 3'd6, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 3'd6, C6,    3'd6, 1'b0};
        vecs[19] = '{1'b0, 1'b1, 3'd6, C6,    3'd6, 1'b0};
        vecs[20] = '{1'b1, 1'b0, 3'd2, 24'h0, 3'd6, 1'b1}; // request on boundary: no commit
        vecs[21] = '{1'b1, 1'b0, 3'd2, 24'h0, 3'd6, 1'b1}; // vsync held: not a boundary
        vecs[22] = '{1'b0, 1'b1, 3'd2, C6,    3'd6, 1'b1};
        vecs[23] = '{1'b1, 1'b0, 3'd2, 24'h0, 3'd2, 1'b0}; // next boundary commits
        vecs[24] = '{1'b0, 1'b1, 3'd2, C2,    3'd2, 1'b0};

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Basic pass-through and switching on dut A
        for (int i = 0; i < 25; i++) begin
            step(1'b0, vecs[i].vs, vecs[i].de, 1'(i % 2), vecs[i].sw,
                 vecs[i].rgb, vecs[i].act, vecs[i].pend);
        end

        // Fresh start for dut B
        @(negedge clk);
        rst = 1'b1; sw = 3'd0; i_vsync = 1'b0; i_de = 1'b0; i_hsync = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Out-of-range requests (7, then 6) over three frames: ignored
        for (int f = 0; f < 3; f++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, (f == 1) ? 3'd6 : 3'd7, 24'h0, 3'd0, 1'b0);
            for (int p = 0; p < 3; p++) begin
                step(1'b1, 1'b0, 1'b1, 1'(p % 2), (f == 1) ? 3'd6 : 3'd7, C0, 3'd0, 1'b0);
            end
        end

        // Switch 0->2 with two black frames
        step(1'b1, 1'b0, 1'b1, 1'b0, 3'd2, C0, 3'd0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 3'd2, C0, 3'd0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 24'h0, 3'd2, 1'b0); // commit, blank frame 1
        step(1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 24'h0, 3'd2, 1'b1); // request held while blanking
        step(1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 24'h0, 3'd2, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 24'h0, 3'd2, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 24'h0, 3'd2, 1'b0); // blank frame 2
        for (int p = 0; p < 3; p++) begin
            step(1'b1, 1'b0, 1'b1, 1'(p % 2), 3'd2, 24'h0, 3'd2, 1'b0);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 24'h0, 3'd2, 1'b0); // blanking ends
        for (int p = 0; p < 3; p++) begin
            step(1'b1, 1'b0, 1'b1, 1'(p % 2), 3'd2, C2, 3'd2, 1'b0);
        end

        // Switch to 3, then reset in the middle of the blank frame
        step(1'b1, 1'b0, 1'b1, 1'b1, 3'd3, C2, 3'd2, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 24'h0, 3'd3, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 24'h0, 3'd3, 1'b0);
        #2;
        sw  = 3'd0;
        rst = 1'b1;
        #1;
        chk("async_rst_b_act", 32'(b_act), 32'd0);
        chk("async_rst_b_de",  32'(b_de),  32'd0);
        chk("async_rst_b_hs",  32'(b_hs),  32'd0);
        chk("async_rst_b_rgb", 32'(b_rgb), 32'd0);
        chk("async_rst_b_pend", 32'(b_pend), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, C0, 3'd0, 1'b0);    // ch0 at once
        step(1'b1, 1'b0, 1'b1, 1'b1, 3'd4, C0, 3'd0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 24'h0, 3'd4, 1'b0); // switching resumes

        if (sb.size() != 0) begin
            chk("scoreboard_leftover", 32'(sb.size()), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
